// File: rtl/deglitch_filter_mc_pkg.sv
// Shared constants for the multi-channel deglitch filter.
// Holds the default counter width, delay-line depth, idle level and the
// I2C channel indices used when the filter cleans up SCL/SDA.
package deglitch_filter_mc_pkg;

  localparam int unsigned N_CH_DEF    = 2;
  localparam int unsigned CNT_W_DEF   = 4;
  localparam int unsigned DLY_N_DEF   = 4;
  localparam logic        RST_VAL_DEF = 1'b1;

  // I2C channel indices
  localparam int unsigned CH_SCL = 0;
  localparam int unsigned CH_SDA = 1;

endpackage

// File: rtl/deglitch_filter_mc_ch.sv
// Single deglitch channel: 2-flop synchronizer, stability counter, filtered
// output, registered edge detect and a fixed-depth delay line.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   in             raw asynchronous input
//   byp            bypass: every synchronized change passes straight through
//   flt_len        required stable length in cycles (0 behaves as 1)
//   out            filtered level
//   dout           out delayed by DLY_N cycles
//   rise, fall     one-cycle pulses while out shows a new level
module deglitch_ch
  import deglitch_filter_mc_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DLY_N   = DLY_N_DEF,
  parameter logic        RST_VAL = RST_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             byp,
  input  logic [CNT_W-1:0] flt_len,
  output logic             out,
  output logic             dout,
  output logic             rise,
  output logic             fall
);

  logic             sync1_q;
  logic             s_q;
  logic             out_q, out_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLY_N-1:0] dly_q;

  // One extra bit so cnt+1 cannot overflow before the compare
  logic [CNT_W:0]   len_eff;
  logic [CNT_W:0]   cnt_inc;

  always_comb begin
    len_eff = (flt_len == '0) ? (CNT_W+1)'(1) : {1'b0, flt_len};
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    out_d   = out_q;
    cnt_d   = '0;
    if (byp) begin
      out_d = s_q;
    end else if (s_q != out_q) begin
      if (cnt_inc >= len_eff) begin
        out_d = s_q;
      end else begin
        // cnt_inc < len_eff here, so the truncation is lossless
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      s_q     <= RST_VAL;
      out_q   <= RST_VAL;
      prev_q  <= RST_VAL;
      cnt_q   <= '0;
      dly_q   <= {DLY_N{RST_VAL}};
    end else begin
      sync1_q  <= in;
      s_q      <= sync1_q;
      out_q    <= out_d;
      prev_q   <= out_q;
      cnt_q    <= cnt_d;
      dly_q[0] <= out_q;
      for (int k = 1; k < int'(DLY_N); k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
  end

  assign out  = out_q;
  assign dout = dly_q[DLY_N-1];
  assign rise = out_q & ~prev_q;
  assign fall = ~out_q & prev_q;

endmodule

// File: rtl/deglitch_filter_mc.sv
// Multi-channel deglitch filter (e.g. I2C SCL/SDA). Each channel is filtered
// independently by its own deglitch_ch; bypass and filter length are shared.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   in[N_CH]       raw asynchronous channel inputs
//   byp            filter bypass
//   flt_len        required stable length in cycles (0 behaves as 1)
//   out[N_CH]      filtered levels
//   dout[N_CH]     out delayed by DLY_N cycles
//   rise/fall      per-channel edge pulses on out
module deglitch_filter_mc
  import deglitch_filter_mc_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DLY_N   = DLY_N_DEF,
  parameter logic        RST_VAL = RST_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in,
  input  logic             byp,
  input  logic [CNT_W-1:0] flt_len,
  output logic [N_CH-1:0]  out,
  output logic [N_CH-1:0]  dout,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall
);

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    deglitch_ch #(
      .CNT_W   (CNT_W),
      .DLY_N   (DLY_N),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in      (in[g]),
      .byp     (byp),
      .flt_len (flt_len),
      .out     (out[g]),
      .dout    (dout[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

endmodule

// File: tb/tb_deglitch_filter_mc.sv
// Self-checking bench for deglitch_filter_mc. A behavioural model tracks, per
// channel, the synchronized samples seen since OUT last agreed with them and
// flips OUT once L such samples have accumulated; directed scenarios also
// check absolute latencies and pulse widths.
module tb_deglitch_filter_mc;

  localparam int unsigned N_CH    = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DLY_N   = 4;
  localparam logic        RST_VAL = 1'b1;
  localparam logic [N_CH-1:0] RV  = {N_CH{RST_VAL}};

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  in_r;
  logic             byp;
  logic [CNT_W-1:0] flt_len;
  logic [N_CH-1:0]  out, dout, rise, fall;
  logic [4*N_CH-1:0] got_vec;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  deglitch_filter_mc #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DLY_N   (DLY_N),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in_r),
    .byp     (byp),
    .flt_len (flt_len),
    .out     (out),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall)
  );

  assign got_vec = {out, dout, rise, fall};

  // ---------------- reference model ----------------
  logic [N_CH-1:0] m_sync1, m_s, m_out, m_prev, m_dout;
  bit              m_hist [N_CH][$];  // synchronized samples since OUT last agreed
  logic [N_CH-1:0] m_oq [$];          // OUT history, oldest first

  task automatic model_edge();
    int l;
    int run;
    logic [N_CH-1:0] nxt;
    if (rst) begin
      m_sync1 = RV; m_s = RV; m_out = RV; m_prev = RV; m_dout = RV;
      for (int c = 0; c < int'(N_CH); c++) m_hist[c].delete();
      m_oq.delete();
      for (int k = 0; k <= int'(DLY_N); k++) m_oq.push_back(RV);
      return;
    end
    l = (flt_len == 0) ? 1 : int'(flt_len);
    nxt = m_out;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (byp) begin
        nxt[c] = m_s[c];
        m_hist[c].delete();
      end else begin
        m_hist[c].push_back(m_s[c]);
        run = 0;
        for (int k = m_hist[c].size() - 1; k >= 0; k--) begin
          if (m_hist[c][k] == m_out[c]) break;
          run++;
        end
        if (run == 0) m_hist[c].delete();
        else if (run >= l) begin
          nxt[c] = m_s[c];
          m_hist[c].delete();
        end
      end
    end
    m_prev = m_out;
    m_out  = nxt;
    m_oq.push_back(nxt);
    void'(m_oq.pop_front());
    m_dout = m_oq[0];
    m_s     = m_sync1;
    m_sync1 = in_r;
  endtask

  function automatic logic [4*N_CH-1:0] exp_vec();
    return {m_out, m_dout, m_out & ~m_prev, ~m_out & m_prev};
  endfunction

  // One clock edge with the currently driven inputs; returns 1ns after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; byp = 1'b0; flt_len = 4'd4;
    for (int k = 0; k < 3; k++) begin
      in_r = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (got_vec !== {RV, RV, 2'b00, 2'b00}) begin
        failures++;
        $display("FAIL reset_state got=%b exp=%b", got_vec, {RV, RV, 2'b00, 2'b00});
      end
    end
    in_r = 2'b11;
    rst  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_hold_fall();
    int fidx = -1, didx = -1, nfall = 0;
    flt_len = 4'd4; byp = 1'b0; in_r = 2'b11;
    settle(8);
    in_r = 2'b10;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL hold_fall_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
      if (out[0] == 1'b0 && fidx < 0) fidx = k;
      if (dout[0] == 1'b0 && didx < 0) didx = k;
      if (fall[0]) nfall++;
    end
    // sampling edge is edge 1 of L+2, i.e. index L+1 from it
    checks++;
    if (fidx != 5) begin
      failures++; $display("FAIL hold_fall_latency got=%0d exp=5", fidx);
    end
    checks++;
    if (nfall != 1) begin
      failures++; $display("FAIL hold_fall_pulse got=%0d exp=1", nfall);
    end
    checks++;
    if (didx != 5 + int'(DLY_N)) begin
      failures++; $display("FAIL hold_fall_dout got=%0d exp=%0d", didx, 5 + int'(DLY_N));
    end
    in_r = 2'b11;
    settle(16);
  endtask

  task automatic test_glitch();
    int lows, falls;
    flt_len = 4'd4; byp = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      in_r = 2'b11;
      settle(12);
      lows = 0; falls = 0;
      for (int k = 0; k < w + 16; k++) begin
        in_r = (k < w) ? 2'b10 : 2'b11;
        tick();
        checks++;
        if (got_vec !== exp_vec()) begin
          failures++;
          $display("FAIL glitch_model w=%0d k=%0d got=%b exp=%b", w, k, got_vec, exp_vec());
        end
        if (!out[0]) lows++;
        if (fall[0]) falls++;
      end
      checks++;
      if (lows != ((w == 4) ? 4 : 0) || falls != ((w == 4) ? 1 : 0)) begin
        failures++;
        $display("FAIL glitch_width w=%0d got lows=%0d falls=%0d exp lows=%0d falls=%0d",
                 w, lows, falls, (w == 4) ? 4 : 0, (w == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_glitch_restart();
    int fidx = -1, early = 0;
    flt_len = 4'd8; byp = 1'b0; in_r = 2'b11;
    settle(16);
    for (int k = 0; k < 6; k++) begin
      in_r = (k < 5) ? 2'b10 : 2'b11;
      tick();
      if (!out[0]) early++;
    end
    in_r = 2'b10;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL restart_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
      if (!out[0] && fidx < 0) fidx = k;
    end
    checks++;
    if (early != 0 || fidx != 9) begin
      failures++;
      $display("FAIL restart_latency got early=%0d idx=%0d exp early=0 idx=9", early, fidx);
    end
    in_r = 2'b11;
    settle(20);
  endtask

  task automatic test_len_decrease();
    int flip_k = -1;
    flt_len = 4'd8; byp = 1'b0; in_r = 2'b11;
    settle(16);
    in_r = 2'b10;
    for (int k = 0; k < 7; k++) tick();  // counter now at 5
    flt_len = 4'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL len_dec_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
      if (!out[0] && flip_k < 0) flip_k = k;
    end
    checks++;
    if (flip_k != 0) begin
      failures++; $display("FAIL len_dec_immediate got=%0d exp=0", flip_k);
    end
    in_r = 2'b11;
    settle(16);
  endtask

  task automatic test_bypass();
    logic [N_CH-1:0] ins [40];
    byp = 1'b1; flt_len = 4'd15;
    for (int k = 0; k < 40; k++) begin
      in_r = 2'($urandom_range(0, 3));
      ins[k] = in_r;
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bypass_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
      if (k >= 2) begin
        checks++;
        if (out !== ins[k-2]) begin
          failures++;
          $display("FAIL bypass_latency k=%0d got=%b exp=%b", k, out, ins[k-2]);
        end
      end
    end
    byp = 1'b0; in_r = 2'b11;
    settle(20);
  endtask

  task automatic test_len0_vs_1();
    logic [N_CH-1:0] stim [60];
    logic [N_CH-1:0] tr0 [60];
    int hold = 0;
    logic [N_CH-1:0] cur = 2'b11;
    for (int k = 0; k < 60; k++) begin
      if (hold == 0) begin
        cur  = 2'($urandom_range(0, 3));
        hold = int'($urandom_range(1, 4));
      end
      hold--;
      stim[k] = cur;
    end
    byp = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      in_r = 2'b11;
      do_reset();
      flt_len = (pass == 0) ? 4'd0 : 4'd1;
      for (int k = 0; k < 60; k++) begin
        in_r = stim[k];
        tick();
        checks++;
        if (got_vec !== exp_vec()) begin
          failures++;
          $display("FAIL len01_model pass=%0d k=%0d got=%b exp=%b", pass, k, got_vec, exp_vec());
        end
        if (pass == 0) tr0[k] = out;
        else begin
          checks++;
          if (out !== tr0[k]) begin
            failures++;
            $display("FAIL len0_vs_len1 k=%0d got=%b exp=%b", k, out, tr0[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    int fidx = -1, stray = 0, tidx = -1;
    logic both_ok = 1'b0;
    flt_len = 4'd8; byp = 1'b0; in_r = 2'b11;
    settle(16);
    in_r = 2'b10;
    for (int k = 0; k < 7; k++) tick();  // counter at 5 of 8
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rst_mid_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
      if (k == 0) begin
        checks++;
        if (got_vec !== {RV, RV, 2'b00, 2'b00}) begin
          failures++;
          $display("FAIL rst_mid_release got=%b exp=%b", got_vec, {RV, RV, 2'b00, 2'b00});
        end
      end
      if (!out[0] && fidx < 0) fidx = k;
      if (fidx < 0 && (rise != 0 || fall != 0)) stray++;
    end
    // a discarded count means the full L+1 edges from the first sampling edge
    checks++;
    if (fidx != 9 || stray != 0) begin
      failures++;
      $display("FAIL rst_mid_recount got idx=%0d stray=%0d exp idx=9 stray=0", fidx, stray);
    end
    in_r = 2'b01;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL simul_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
      if (out != 2'b10 && tidx < 0) begin
        tidx = k;
        both_ok = (out == 2'b01) && (rise == 2'b01) && (fall == 2'b10);
      end
    end
    checks++;
    if (tidx != 9 || !both_ok) begin
      failures++;
      $display("FAIL simul_toggle got idx=%0d same_cycle=%0b exp idx=9 same_cycle=1",
               tidx, both_ok);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        in_r = 2'($urandom_range(0, 3));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 29) == 0) flt_len = 4'($urandom_range(0, 15));
      byp = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_model k=%0d got=%b exp=%b", k, got_vec, exp_vec());
      end
    end
    byp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_r = 2'b11; byp = 1'b0; flt_len = 4'd4;
    test_reset();
    test_hold_fall();
    test_glitch();
    test_glitch_restart();
    test_len_decrease();
    test_bypass();
    test_len0_vs_1();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
